if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline CPU; sits directly upstream of the IF/ID pipeline register and produces its `pc_next` and `memi_out` inputs. Owns the fetch PC, issues in-order requests to the instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions in a small FIFO. The FIFO absorbs ID-stage stalls. Handles redirects from branch/jump resolution and discards stale in-flight responses.

---
 rtl/if_fetch_stage_pkg.sv | 16 +
 rtl/if_fetch_stage_fetch_fifo.sv | 75 +++++++
 rtl/if_fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_stage_pkg;

    // Instruction word presented downstream when nothing is buffered.
    localparam int NOP_INSTR      = 0;
    // Byte distance between consecutive instruction words.
    localparam int PC_INC         = 4;
    // Default instruction buffer depth (power of 2, at least 3).
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr} pairs.
// Clear beats push and pop; a push into a full buffer is ignored unless a pop
// frees a slot in the same cycle.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_pc_i,
    input  logic [WIDTH-1:0] push_instr_i,
    output logic [WIDTH-1:0] head_pc_o,
    output logic [WIDTH-1:0] head_instr_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against clear and occupancy.
    always_comb begin
        do_pop  = pop_i & ~clear_i & (count_q != '0);
        do_push = push_i & ~clear_i & ((count_q != CW'(DEPTH)) | do_pop);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests over
// req/gnt/rvalid, buffers responses and hands the head to the IF/ID register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | issuing requests, responses are pushed into the buffer
// ST_FLUSH | after a redirect: no requests, stale responses are dropped
//
// In ST_FLUSH every outstanding response is stale, so outstanding == discard;
// in ST_RUN discard is 0. Because the FSM only returns to ST_RUN with nothing
// in flight, requests since then are address-contiguous and the PC of the
// oldest outstanding response is fetch_pc - 4 * outstanding.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                 WIDTH_I    = 32,
    parameter logic [WIDTH_I-1:0] RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_ctrl,
    input  logic               redirect_valid,
    input  logic [WIDTH_I-1:0] redirect_pc,
    output logic               imem_req,
    output logic [WIDTH_I-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [WIDTH_I-1:0] imem_rdata,
    output logic [WIDTH_I-1:0] pc_next,
    output logic [WIDTH_I-1:0] memi_out
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [WIDTH_I-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      discard_q, discard_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_clear;
    logic [WIDTH_I-1:0] fifo_head_pc;
    logic [WIDTH_I-1:0] fifo_head_instr;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;

    logic [CW:0]        inflight;
    logic               credit_ok;
    logic               grant;
    logic [CW-1:0]      rem_out;
    logic [WIDTH_I-1:0] resp_pc;
    logic [WIDTH_I-1:0] redirect_tgt;

    // Low address bits of the redirect target are forced to zero.
    logic               unused_rpc_lsb;
    assign unused_rpc_lsb = ^redirect_pc[1:0];
    assign redirect_tgt   = {redirect_pc[WIDTH_I-1:2], 2'b00};

    // Request issue: bounded by buffer credit, withdrawn only by a redirect.
    always_comb begin
        inflight  = (CW + 1)'(outst_q) + (CW + 1)'(fifo_count);
        credit_ok = (inflight < (CW + 1)'(FIFO_DEPTH));
        imem_req  = rst_n & (state_q == ST_RUN) & ~redirect_valid & credit_ok;
        imem_addr = fetch_pc_q;
        grant     = imem_req & imem_gnt;
    end

    // Responses still expected after this cycle, and the PC of the one arriving now.
    always_comb begin
        rem_out = outst_q;
        if (imem_rvalid && (outst_q != '0)) begin
            rem_out = outst_q - CW'(1);
        end
        resp_pc = fetch_pc_q - (WIDTH_I'(outst_q) * WIDTH_I'(PC_INC));
    end

    // Next-state logic for the FSM, fetch PC, counters and buffer control.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        fifo_pop   = ~fifo_empty & ~stall_ctrl & ~redirect_valid;

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fifo_clear = 1'b1;
            fetch_pc_d = redirect_tgt;
            outst_d    = rem_out;
            discard_d  = rem_out;
            state_d    = (rem_out != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (grant) begin
                        fetch_pc_d = fetch_pc_q + WIDTH_I'(PC_INC);
                    end
                    fifo_push = imem_rvalid;
                    case ({grant, imem_rvalid})
                        2'b10:   outst_d = outst_q + CW'(1);
                        2'b01:   outst_d = rem_out;
                        default: outst_d = outst_q;
                    endcase
                end
                ST_FLUSH: begin
                    if (imem_rvalid) begin
                        outst_d = rem_out;
                        if (discard_q != '0) begin
                            discard_d = discard_q - CW'(1);
                        end
                        if (discard_q <= CW'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH_I),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (fifo_clear),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .push_pc_i    (resp_pc),
        .push_instr_i (imem_rdata),
        .head_pc_o    (fifo_head_pc),
        .head_instr_o (fifo_head_instr),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty)
    );

    // Downstream view of the buffer head; NOP and PC 0 when empty.
    always_comb begin
        if (fifo_empty) begin
            pc_next  = '0;
            memi_out = WIDTH_I'(NOP_INSTR);
        end else begin
            pc_next  = fifo_head_pc + WIDTH_I'(PC_INC);
            memi_out = fifo_head_instr;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small in-order memory model that
// answers each grant after a programmable latency with rdata = addr | 0x13.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_ctrl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_next;
    logic [31:0] memi_out;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc;
    int          lat;
    int          n_total;
    int          n_bad;
    logic [31:0] exp_head;

    if_fetch_stage #(
        .WIDTH_I    (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_ctrl     (stall_ctrl),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_next        (pc_next),
        .memi_out       (memi_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; the memory model records this cycle's handshake and
    // drives the response for the next cycle.
    task automatic tick();
        logic        hs;
        logic        rv;
        logic [31:0] a;
        #1;
        hs = imem_req & imem_gnt;
        rv = imem_rvalid;
        a  = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (hs) mq.push_back('{addr: a, due: cyc - 1 + lat});
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr | 32'h13;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n          = 1'b0;
        stall_ctrl     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_total        = 0;
        n_bad          = 0;
        cyc            = 0;
        lat            = 1;
        rst_n          = 1'b0;
        stall_ctrl     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_memi", memi_out, 32'h0);
            chk("rst_pcnext", pc_next, 32'h0);
            chk("rst_req", {31'b0, imem_req}, 32'h0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);

        // Zero-wait streaming.
        tick();
        chk("stream_empty", memi_out, 32'h0);
        tick();
        exp_head = 32'h0;
        for (int i = 0; i < 6; i++) begin
            chk("stream_memi", memi_out, exp_head | 32'h13);
            chk("stream_pcnext", pc_next, exp_head + 32'd4);
            exp_head += 32'd4;
            tick();
        end

        // Six-cycle stall: head held, request drops once four are in flight.
        stall_ctrl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("stall_hold", pc_next, exp_head + 32'd4);
            if (i >= 2) chk("stall_req", {31'b0, imem_req}, 32'h0);
            tick();
        end
        stall_ctrl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("resume_memi", memi_out, exp_head | 32'h13);
            chk("resume_pcnext", pc_next, exp_head + 32'd4);
            exp_head += 32'd4;
            tick();
        end

        // Redirect with two responses in flight on a 3-cycle memory.
        lat = 3;
        do_reset(2);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h101;
        #1;
        chk("redir_req_off", {31'b0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("flush_req0", {31'b0, imem_req}, 32'h0);
        chk("flush_memi0", memi_out, 32'h0);
        tick();
        chk("flush_req1", {31'b0, imem_req}, 32'h0);
        chk("flush_memi1", memi_out, 32'h0);
        tick();
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        chk("redir_addr2", imem_addr, 32'h104);
        chk("redir_memi_e", memi_out, 32'h0);
        tick();
        tick();
        chk("redir_memi_e2", memi_out, 32'h0);
        tick();
        chk("redir_memi", memi_out, 32'h113);
        chk("redir_pcnext", pc_next, 32'h104);

        // Redirect and stall together with three buffered entries.
        lat = 1;
        do_reset(2);
        stall_ctrl = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rs_head", memi_out, 32'h13);
        chk("rs_head_pc", pc_next, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        #1;
        chk("rs_req_off", {31'b0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        stall_ctrl     = 1'b0;
        #1;
        chk("rs_memi_nop", memi_out, 32'h0);
        chk("rs_pcnext0", pc_next, 32'h0);
        chk("rs_req", {31'b0, imem_req}, 32'h1);
        chk("rs_addr", imem_addr, 32'h2000);
        tick();
        tick();
        chk("rs_memi", memi_out, 32'h2013);
        chk("rs_pcnext", pc_next, 32'h2004);

        // Grant back-pressure.
        do_reset(2);
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req", {31'b0, imem_req}, 32'h1);
            chk("bp_addr", imem_addr, 32'h0);
            chk("bp_memi", memi_out, 32'h0);
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        chk("bp_addr_g", imem_addr, 32'h0);
        tick();
        chk("bp_addr_adv", imem_addr, 32'h4);
        tick();
        chk("bp_memi", memi_out, 32'h13);
        chk("bp_pcnext", pc_next, 32'h4);

        // Address wrap-around.
        do_reset(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("wrap_req_off", {31'b0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        tick();
        chk("wrap_memi0", memi_out, 32'hFFFF_FFFF);
        chk("wrap_pcnext0", pc_next, 32'h0);
        tick();
        chk("wrap_memi1", memi_out, 32'h13);
        chk("wrap_pcnext1", pc_next, 32'h4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
